// File: rtl/pcie_mac_pkg.sv
// Shared MAC constants, legal striping configurations and beats-per-word helper.
package pcie_mac_pkg;

    localparam int MAX_LANES  = 16;
    localparam int WORD_BYTES = 64;

    localparam logic [5:0] PW_8  = 6'd8;
    localparam logic [5:0] PW_16 = 6'd16;
    localparam logic [5:0] PW_32 = 6'd32;

    localparam logic [4:0] LN_1  = 5'd1;
    localparam logic [4:0] LN_2  = 5'd2;
    localparam logic [4:0] LN_4  = 5'd4;
    localparam logic [4:0] LN_8  = 5'd8;
    localparam logic [4:0] LN_16 = 5'd16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic cfg_legal(input logic [5:0] pw, input logic [4:0] ln);
        logic pw_ok;
        logic ln_ok;
        pw_ok = (pw == PW_8) || (pw == PW_16) || (pw == PW_32);
        ln_ok = (ln == LN_1) || (ln == LN_2) || (ln == LN_4) || (ln == LN_8) || (ln == LN_16);
        return pw_ok && ln_ok;
    endfunction

    // Output beats needed for one 64-byte word; collapses to 1 for illegal settings.
    function automatic logic [6:0] num_beats(input logic [5:0] pw, input logic [4:0] ln);
        int bytes_per_beat;
        logic [6:0] nb;
        bytes_per_beat = int'(ln) * (int'(pw) / 8);
        if (!cfg_legal(pw, ln) || bytes_per_beat == 0) begin
            nb = 7'd1;
        end else begin
            nb = 7'(WORD_BYTES / bytes_per_beat);
        end
        return nb;
    endfunction

endpackage

// File: rtl/striping_if.sv
// Byte-stream input handshake and striped lane output bundle.
interface striping_if #(
    parameter int MAX_LANES = pcie_mac_pkg::MAX_LANES
);
    logic [511:0]             unstripedData;
    logic [63:0]              unstripedDataK;
    logic                     dataValid;
    logic                     dataReady;
    logic [MAX_LANES*32-1:0]  stripedData;
    logic [MAX_LANES*4-1:0]   stripedDataK;
    logic                     stripedValid;

    modport master (
        output unstripedData,
        output unstripedDataK,
        output dataValid,
        input  dataReady,
        input  stripedData,
        input  stripedDataK,
        input  stripedValid
    );

    modport slave (
        input  unstripedData,
        input  unstripedDataK,
        input  dataValid,
        output dataReady,
        output stripedData,
        output stripedDataK,
        output stripedValid
    );
endinterface

// File: rtl/striping_beat_mux.sv
// Combinational selection of one striped beat out of a held 64-byte word.
module striping_beat_mux #(
    parameter int MAX_LANES = pcie_mac_pkg::MAX_LANES
) (
    input  logic [511:0]            hold_data,
    input  logic [63:0]             hold_k,
    input  logic [5:0]              beat,
    input  logic [5:0]              pw,
    input  logic [4:0]              ln,
    output logic [MAX_LANES*32-1:0] beat_data,
    output logic [MAX_LANES*4-1:0]  beat_k
);
    import pcie_mac_pkg::*;

    logic [7:0] byte_at [WORD_BYTES];
    logic       k_at    [WORD_BYTES];
    int         lanes;
    int         width;

    for (genvar i = 0; i < WORD_BYTES; i++) begin : gen_byte
        assign byte_at[i] = hold_data[511-8*i -: 8];
        assign k_at[i]    = hold_k[63-i];
    end

    assign lanes = int'(ln);
    assign width = int'(pw) / 8;

    // Lane L slot j carries stream byte beat*B + j*lanes + L, the inverse of the striping order.
    for (genvar l = 0; l < MAX_LANES; l++) begin : gen_lane
        for (genvar j = 0; j < 4; j++) begin : gen_slot
            int   idx;
            logic on;
            assign idx = int'(beat) * lanes * width + j * lanes + l;
            assign on  = (l < lanes) && (j < width) && (idx < WORD_BYTES);
            assign beat_data[l*32+8*j +: 8] = on ? byte_at[idx[5:0]] : 8'h00;
            assign beat_k[l*4+j]            = on & k_at[idx[5:0]];
        end
    end

endmodule

// File: rtl/striping.sv
// Stripes a 64-byte stream word across active lanes over NB beats with registered outputs.
module striping #(
    parameter int MAX_LANES = pcie_mac_pkg::MAX_LANES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] PIPEWIDTH,
    input  logic [4:0] LANESNUMBER,
    striping_if.slave  bus,
    output logic       cfgError
);
    import pcie_mac_pkg::*;

    state_t       state;
    logic [5:0]   beat_cnt;
    logic [5:0]   last_q;
    logic [511:0] hold_data;
    logic [63:0]  hold_k;
    logic [5:0]   pw_q;
    logic [4:0]   ln_q;

    logic         last_beat;
    logic         accept;
    logic         cfg_ok;
    logic [511:0] sel_data;
    logic [63:0]  sel_k;
    logic [5:0]   sel_beat;
    logic [5:0]   sel_pw;
    logic [4:0]   sel_ln;

    logic [MAX_LANES*32-1:0] mux_data;
    logic [MAX_LANES*4-1:0]  mux_k;

    assign last_beat     = (state == SEND) && (beat_cnt == last_q);
    assign bus.dataReady = (state == IDLE) || last_beat;
    assign accept        = bus.dataValid && bus.dataReady;
    assign cfg_ok        = cfg_legal(PIPEWIDTH, LANESNUMBER);

    // On accept the output register loads beat 0 of the incoming word directly.
    assign sel_data = accept ? bus.unstripedData  : hold_data;
    assign sel_k    = accept ? bus.unstripedDataK : hold_k;
    assign sel_beat = accept ? 6'd0               : beat_cnt + 6'd1;
    assign sel_pw   = accept ? PIPEWIDTH          : pw_q;
    assign sel_ln   = accept ? LANESNUMBER        : ln_q;

    striping_beat_mux #(
        .MAX_LANES (MAX_LANES)
    ) u_beat_mux (
        .hold_data (sel_data),
        .hold_k    (sel_k),
        .beat      (sel_beat),
        .pw        (sel_pw),
        .ln        (sel_ln),
        .beat_data (mux_data),
        .beat_k    (mux_k)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            beat_cnt         <= 6'd0;
            last_q           <= 6'd0;
            hold_data        <= '0;
            hold_k           <= '0;
            pw_q             <= 6'd0;
            ln_q             <= 5'd0;
            bus.stripedData  <= '0;
            bus.stripedDataK <= '0;
            bus.stripedValid <= 1'b0;
            cfgError         <= 1'b0;
        end else begin
            cfgError <= 1'b0;
            if (accept && cfg_ok) begin
                state            <= SEND;
                beat_cnt         <= 6'd0;
                last_q           <= 6'(num_beats(PIPEWIDTH, LANESNUMBER) - 7'd1);
                hold_data        <= bus.unstripedData;
                hold_k           <= bus.unstripedDataK;
                pw_q             <= PIPEWIDTH;
                ln_q             <= LANESNUMBER;
                bus.stripedData  <= mux_data;
                bus.stripedDataK <= mux_k;
                bus.stripedValid <= 1'b1;
            end else if (accept) begin
                // Illegal configuration: the word is consumed but never streamed.
                state            <= IDLE;
                beat_cnt         <= 6'd0;
                bus.stripedData  <= '0;
                bus.stripedDataK <= '0;
                bus.stripedValid <= 1'b0;
                cfgError         <= 1'b1;
            end else if (state == SEND && !last_beat) begin
                beat_cnt         <= beat_cnt + 6'd1;
                bus.stripedData  <= mux_data;
                bus.stripedDataK <= mux_k;
            end else begin
                state            <= IDLE;
                beat_cnt         <= 6'd0;
                bus.stripedData  <= '0;
                bus.stripedDataK <= '0;
                bus.stripedValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_striping.sv
// Directed and randomized bench for striping against a forward byte-placement model.
module tb_striping;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] pw;
    logic [4:0] ln;
    logic       cfg_error;

    striping_if bus();

    striping #(.MAX_LANES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .PIPEWIDTH   (pw),
        .LANESNUMBER (ln),
        .bus         (bus),
        .cfgError    (cfg_error)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [511:0] exp_d [64];
    logic [63:0]  exp_k [64];
    int           exp_nb;
    logic [511:0] seq_word;
    logic [511:0] w2;
    logic [5:0]   pw_tab [3];
    logic [4:0]   ln_tab [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[9'(i*32) +: 32] = $urandom;
        return r;
    endfunction

    // Walk the stream in order and drop each byte where the striping rules put it.
    task automatic model(input logic [5:0] p, input logic [4:0] l,
                         input logic [511:0] d, input logic [63:0] k);
        int w, bpb, b, m, lane, slot;
        w      = int'(p) / 8;
        bpb    = int'(l) * w;
        exp_nb = 64 / bpb;
        for (int i = 0; i < 64; i++) begin
            exp_d[6'(i)] = '0;
            exp_k[6'(i)] = '0;
        end
        for (int n = 0; n < 64; n++) begin
            b    = n / bpb;
            m    = n % bpb;
            lane = m % int'(l);
            slot = m / int'(l);
            exp_d[6'(b)][9'(lane*32 + slot*8) +: 8] = d[9'(511 - 8*n) -: 8];
            exp_k[6'(b)][6'(lane*4 + slot)]         = k[6'(63 - n)];
        end
    endtask

    task automatic check_beat(input string tag, input int b);
        chk($sformatf("%s.b%0d.data", tag, b), bus.stripedData, exp_d[6'(b)]);
        chk($sformatf("%s.b%0d.k", tag, b), 512'(bus.stripedDataK), 512'(exp_k[6'(b)]));
        chk($sformatf("%s.b%0d.valid", tag, b), 512'(bus.stripedValid), 512'(1'b1));
        chk($sformatf("%s.b%0d.ready", tag, b), 512'(bus.dataReady), 512'(b == exp_nb - 1));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, 512'(bus.stripedValid), 512'(1'b0));
        chk({tag, ".data"}, bus.stripedData, 512'(0));
        chk({tag, ".k"}, 512'(bus.stripedDataK), 512'(0));
        chk({tag, ".ready"}, 512'(bus.dataReady), 512'(1'b1));
    endtask

    task automatic stream(input string tag, input logic [5:0] p, input logic [4:0] l,
                          input logic [511:0] d, input logic [63:0] k, input bit scramble);
        pw                 = p;
        ln                 = l;
        bus.unstripedData  = d;
        bus.unstripedDataK = k;
        bus.dataValid      = 1'b1;
        model(p, l, d, k);
        step();
        bus.dataValid = 1'b0;
        for (int b = 0; b < exp_nb; b++) begin
            if (b > 0) step();
            if (scramble) begin
                pw                = 6'($urandom_range(0, 63));
                ln                = 5'($urandom_range(0, 31));
                bus.unstripedData = rand512();
            end
            check_beat(tag, b);
        end
        step();
        check_idle({tag, ".after"});
    endtask

    initial begin
        pw_tab = '{6'd8, 6'd16, 6'd32};
        ln_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
        for (int n = 0; n < 64; n++) seq_word[9'(511 - 8*n) -: 8] = 8'(n);
        bus.unstripedData  = '0;
        bus.unstripedDataK = '0;
        bus.dataValid      = 1'b0;
        pw                 = 6'd8;
        ln                 = 5'd1;

        // Reset state
        step();
        check_idle("reset");
        chk("reset.cfgError", 512'(cfg_error), 512'(1'b0));
        #3 reset = 1'b1;
        step();
        check_idle("post_reset");

        // 16 lanes x 32 bits: a single beat
        pw = 6'd32; ln = 5'd16;
        bus.unstripedData = seq_word; bus.unstripedDataK = '0; bus.dataValid = 1'b1;
        model(6'd32, 5'd16, seq_word, 64'd0);
        step();
        bus.dataValid = 1'b0;
        check_beat("x16w32", 0);
        chk("x16w32.lane0", 512'(bus.stripedData[31:0]), 512'(32'h30201000));
        chk("x16w32.lane15", 512'(bus.stripedData[511:480]), 512'(32'h3F2F1F0F));
        step();
        check_idle("x16w32.after");

        // 1 lane x 8 bits: 64 beats
        stream("x1w8", 6'd8, 5'd1, seq_word, 64'd0, 1'b0);

        // 4 lanes x 16 bits with K on byte 5
        pw = 6'd16; ln = 5'd4;
        bus.unstripedData = seq_word; bus.unstripedDataK = 64'd1 << 58; bus.dataValid = 1'b1;
        model(6'd16, 5'd4, seq_word, 64'd1 << 58);
        step();
        bus.dataValid = 1'b0;
        check_beat("x4w16", 0);
        chk("x4w16.b0.lane0", 512'(bus.stripedData[15:0]), 512'(16'h0400));
        chk("x4w16.b0.lane3", 512'(bus.stripedData[111:96]), 512'(16'h0703));
        chk("x4w16.b0.kbit5", 512'(bus.stripedDataK), 512'(64'h20));
        step();
        check_beat("x4w16", 1);
        chk("x4w16.b1.lane0", 512'(bus.stripedData[15:0]), 512'(16'h0C08));
        for (int b = 2; b < 8; b++) begin
            step();
            check_beat("x4w16", b);
        end
        step();
        check_idle("x4w16.after");

        // 8 lanes x 32 bits, two words back to back
        w2 = rand512();
        pw = 6'd32; ln = 5'd8;
        bus.unstripedData = seq_word; bus.unstripedDataK = '0; bus.dataValid = 1'b1;
        model(6'd32, 5'd8, seq_word, 64'd0);
        step();
        bus.unstripedData = w2;
        check_beat("b2b.w1", 0);
        step();
        check_beat("b2b.w1", 1);
        model(6'd32, 5'd8, w2, 64'd0);
        step();
        bus.dataValid = 1'b0;
        check_beat("b2b.beat2", 0);
        step();
        check_beat("b2b.beat3", 1);
        step();
        check_idle("b2b.after");

        // Reset asserted on beat 20 of a 1x8 word
        pw = 6'd8; ln = 5'd1;
        bus.unstripedData = seq_word; bus.unstripedDataK = '0; bus.dataValid = 1'b1;
        model(6'd8, 5'd1, seq_word, 64'd0);
        step();
        bus.dataValid = 1'b0;
        for (int b = 0; b <= 20; b++) begin
            if (b > 0) step();
            check_beat("rst_mid", b);
        end
        #1 reset = 1'b0;
        #1;
        check_idle("rst_mid.async");
        #1 reset = 1'b1;
        step();
        check_idle("rst_mid.release");
        step();
        check_idle("rst_mid.no_resume");

        // Illegal lane count
        pw = 6'd8; ln = 5'd3;
        bus.unstripedData = seq_word; bus.dataValid = 1'b1;
        step();
        bus.dataValid = 1'b0;
        chk("cfgerr.flag", 512'(cfg_error), 512'(1'b1));
        check_idle("cfgerr");
        step();
        chk("cfgerr.pulse_end", 512'(cfg_error), 512'(1'b0));
        check_idle("cfgerr.next");
        stream("cfgerr.legal", 6'd16, 5'd2, rand512(), {$urandom, $urandom}, 1'b0);

        // Random legal words with configuration churn during SEND
        for (int i = 0; i < 8; i++) begin
            stream($sformatf("rand%0d", i), pw_tab[$urandom_range(0, 2)],
                   ln_tab[$urandom_range(0, 4)], rand512(), {$urandom, $urandom}, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/striping.md
STRIPING -- requirements
Module: striping

Interface
REQ-001 SHALL have parameter MAX_LANES, default 16, maximum lane count; the output bus is MAX_LANES*32 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PIPEWIDTH, input, 6, bits per lane per beat; legal values are 8, 16 and 32.
REQ-005 SHALL have port LANESNUMBER, input, 5, active lane count; legal values are 1, 2, 4, 8 and 16.
REQ-006 SHALL have port unstripedData, input, 512, byte stream word; stream byte n (n=0 first) occupies bits [511-8n -: 8].
REQ-007 SHALL have port unstripedDataK, input, 64, K flag for stream byte n at bit 63-n.
REQ-008 SHALL have port dataValid, input, 1, the input word is valid.
REQ-009 SHALL have port dataReady, output, 1, the block accepts the word this cycle.
REQ-010 SHALL have port stripedData, output, 512, lane L slot j occupies bits [L*32+8j +: 8].
REQ-011 SHALL have port stripedDataK, output, 64, lane L slot j K flag at bit L*4+j.
REQ-012 SHALL have port stripedValid, output, 1, a beat is present on the striped outputs.
REQ-013 SHALL have port cfgError, output, 1, registered flag for an illegal PIPEWIDTH/LANESNUMBER at accept.

Function
REQ-014 SHALL define W=PIPEWIDTH/8 and B=LANESNUMBER*W; each word takes NB=64/B output beats, from 1 to 64.
REQ-015 SHALL place stream byte n in beat b=n/B, with m=n%B, lane m%LANESNUMBER and slot m/LANESNUMBER; K bits follow the same mapping.
REQ-016 SHALL drive zero on all lanes >= LANESNUMBER and all slots >= W in every beat.
REQ-017 SHALL accept a word on a rising edge with dataValid=1 and dataReady=1, and latch the word, its K bits, and the configuration at that edge.
REQ-018 SHALL use a two-state FSM: IDLE goes to SEND on accept; SEND goes to IDLE after beat NB-1 if no new word is accepted.
REQ-019 SHALL drive dataReady combinationally: 1 in IDLE, 1 in SEND only during the last beat, 0 otherwise.
REQ-020 SHALL provide registered outputs; beat 0 of an accepted word appears in the cycle right after the accepting edge (latency 1).
REQ-021 SHALL, when a new word is accepted on the last beat, present its beat 0 in the next cycle with no stripedValid gap.
REQ-022 SHALL hold stripedValid=1 for exactly NB consecutive cycles per word.
REQ-023 SHALL use a 6-bit beat counter that counts 0..NB-1 and wraps to 0 when a back-to-back word is accepted.
REQ-024 SHALL, when stripedValid=0, drive stripedData and stripedDataK to zero.
REQ-025 SHALL ignore configuration changes during SEND; the latched configuration applies.
REQ-026 SHALL, for an illegal configuration at accept, consume and discard the word, set cfgError=1 for one cycle, keep stripedValid=0, and stay in IDLE.

Reset
REQ-027 SHALL, on reset low, asynchronously force state=IDLE, beat counter=0, data/K hold registers=0, stripedData=0, stripedDataK=0, stripedValid=0 and cfgError=0.
REQ-028 SHALL discard a word in progress when reset is asserted mid-word, with no beats resumed after release.

Structure
REQ-029 SHALL place MAX_LANES, the legal PIPEWIDTH and LANESNUMBER values, and the NB computation function in shared package pcie_mac_pkg.
REQ-030 SHALL place the combinational beat-select mapping (hold word, beat index, configuration -> 512/64-bit beat) in sub-module striping_beat_mux; striping holds the FSM, counter and registers.

Verification
In every scenario, stream byte n = n (0x00..0x3F) and dataK = 0 unless stated otherwise.
REQ-031 SHALL cover 16 lanes x 32 bits: one beat; lane0=0x30201000, lane15=0x3F2F1F0F; stripedValid high 1 cycle.
REQ-032 SHALL cover 1 lane x 8 bits: 64 beats; beat b lane0 byte0=b and all other bits 0; dataReady low on beats 0..62 and high on beat 63.
REQ-033 SHALL cover 4 lanes x 16 bits: 8 beats; beat0 lane0=0x0400, lane3=0x0703; beat1 lane0=0x0C08; K bit for byte 5 set -> stripedDataK bit 5 (lane1 slot1) set in beat0.
REQ-034 SHALL cover 8 lanes x 32 bits with two back-to-back words: stripedValid high 4 consecutive cycles; beat2 equals beat0 of word 2.
REQ-035 SHALL cover reset asserted on beat 20 of a 1x8 word: outputs zero immediately; after release, dataReady=1 and stripedValid=0.
REQ-036 SHALL cover LANESNUMBER=3: cfgError pulses 1 cycle, stripedValid stays 0, and the next legal word streams normally.
